// File: rtl/iobus_pkg.sv
// Shared FSM encoding, status-window offsets and helpers for the MCS IO-bus crossbar.
package iobus_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_STAT = 2'd2,
    ST_ERR  = 2'd3
  } state_t;

  localparam logic [2:0]  STAT_OFF_CTRL = 3'd0;
  localparam logic [2:0]  STAT_OFF_ADDR = 3'd4;
  localparam logic [31:0] DEF_ERR_DATA  = 32'hDEADBEEF;

  function automatic int clog2(input int value);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/iobus_addr_dec.sv
// Combinational window decode: lowest-index slave hit wins, status window reported separately.
module iobus_addr_dec
  import iobus_pkg::*;
#(
  parameter int                         NUM_SLAVES  = 4,
  parameter int                         SEL_W       = 2,
  parameter logic [NUM_SLAVES*32-1:0]   P_ADDR_LOW  = {NUM_SLAVES{32'hFFFFFFFF}},
  parameter logic [NUM_SLAVES*32-1:0]   P_ADDR_HI   = {NUM_SLAVES{32'h00000000}},
  parameter logic [31:0]                P_STAT_ADDR = 32'hC000F000
) (
  input  logic [31:0]           i_addr,
  output logic [NUM_SLAVES-1:0] o_hit,
  output logic [SEL_W-1:0]      o_sel,
  output logic                  o_any_hit,
  output logic                  o_stat_hit
);

  // 33-bit top so a status window at the very top of memory does not wrap.
  localparam logic [32:0] STAT_TOP = {1'b0, P_STAT_ADDR} + 33'd7;

  logic [NUM_SLAVES-1:0] w_raw;

  always_comb begin
    w_raw = '0;
    for (int k = 0; k < NUM_SLAVES; k++) begin
      w_raw[k] = (i_addr >= P_ADDR_LOW[32*k +: 32]) && (i_addr <= P_ADDR_HI[32*k +: 32]);
    end
  end

  always_comb begin
    o_sel     = '0;
    o_any_hit = 1'b0;
    for (int k = NUM_SLAVES - 1; k >= 0; k--) begin
      if (w_raw[k]) begin
        o_sel     = SEL_W'(k);
        o_any_hit = 1'b1;
      end
    end
  end

  assign o_hit      = w_raw & (~w_raw + NUM_SLAVES'(1));
  assign o_stat_hit = (i_addr >= P_STAT_ADDR) && ({1'b0, i_addr} <= STAT_TOP);

endmodule

// File: rtl/iobus_xbar.sv
// MCS IO-bus crossbar: 1 master to NUM_SLAVES windows, registered completion, timeout watchdog,
// built-in status window. Strobes forwarded with zero latency; M_Ready always returns.
module iobus_xbar
  import iobus_pkg::*;
#(
  parameter int                       NUM_SLAVES     = 4,
  parameter logic [NUM_SLAVES*32-1:0] P_ADDR_LOW     = {NUM_SLAVES{32'hFFFFFFFF}},
  parameter logic [NUM_SLAVES*32-1:0] P_ADDR_HI      = {NUM_SLAVES{32'h00000000}},
  parameter logic [31:0]              P_STAT_ADDR    = 32'hC000F000,
  parameter int                       TIMEOUT_CYCLES = 255,
  parameter logic [31:0]              P_ERR_DATA     = DEF_ERR_DATA
) (
  input  logic                       i_clk,
  input  logic                       i_reset,
  input  logic                       i_m_addr_strobe,
  input  logic                       i_m_read_strobe,
  input  logic                       i_m_write_strobe,
  input  logic [31:0]                i_m_address,
  input  logic [3:0]                 i_m_byte_enable,
  input  logic [31:0]                i_m_write_data,
  output logic [31:0]                o_m_read_data,
  output logic                       o_m_ready,
  output logic [NUM_SLAVES-1:0]      o_s_addr_strobe,
  output logic [NUM_SLAVES-1:0]      o_s_read_strobe,
  output logic [NUM_SLAVES-1:0]      o_s_write_strobe,
  output logic [31:0]                o_s_address,
  output logic [3:0]                 o_s_byte_enable,
  output logic [31:0]                o_s_write_data,
  input  logic [NUM_SLAVES*32-1:0]   i_s_read_data,
  input  logic [NUM_SLAVES-1:0]      i_s_ready,
  output logic                       o_bus_err_irq
);

  localparam int               SEL_W    = (NUM_SLAVES > 1) ? clog2(NUM_SLAVES) : 1;
  localparam int               TMO_W    = clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);

  state_t             r_state, w_state_nxt;
  logic [SEL_W-1:0]   r_sel;
  logic [TMO_W-1:0]   r_tmo_cnt;
  logic [15:0]        r_err_cnt;
  logic [31:0]        r_last_err_addr, r_rd_data;
  logic               r_overrun, r_ready, r_is_write, r_be_any;

  logic [NUM_SLAVES-1:0] w_hit, w_slv_mask;
  logic [SEL_W-1:0]      w_sel;
  logic                  w_any_hit, w_stat_hit, w_fwd, w_err_ev, w_clr, w_cpl;
  logic [31:0]           w_cpl_data, w_stat_rdata;
  logic [2:0]            w_stat_off;

  iobus_addr_dec #(
    .NUM_SLAVES (NUM_SLAVES),
    .SEL_W      (SEL_W),
    .P_ADDR_LOW (P_ADDR_LOW),
    .P_ADDR_HI  (P_ADDR_HI),
    .P_STAT_ADDR(P_STAT_ADDR)
  ) u_dec (
    .i_addr    (i_m_address),
    .o_hit     (w_hit),
    .o_sel     (w_sel),
    .o_any_hit (w_any_hit),
    .o_stat_hit(w_stat_hit)
  );

  assign w_fwd      = i_m_addr_strobe & (r_state == ST_IDLE) & ~i_reset;
  assign w_slv_mask = (w_fwd & ~w_stat_hit) ? w_hit : '0;

  assign o_s_addr_strobe  = w_slv_mask;
  assign o_s_read_strobe  = {NUM_SLAVES{i_m_read_strobe}} & w_slv_mask;
  assign o_s_write_strobe = {NUM_SLAVES{i_m_write_strobe}} & w_slv_mask;
  assign o_s_address      = i_m_address;
  assign o_s_byte_enable  = i_m_byte_enable;
  assign o_s_write_data   = i_m_write_data;

  assign o_m_read_data = r_rd_data;
  assign o_m_ready     = r_ready;
  assign o_bus_err_irq = (r_err_cnt != 16'd0);

  // Address is held by the master until M_Ready, so the offset is taken live.
  assign w_stat_off = i_m_address[2:0] - P_STAT_ADDR[2:0];
  assign w_clr      = (r_state == ST_STAT) & r_is_write & r_be_any & (w_stat_off == STAT_OFF_CTRL);

  always_comb begin
    w_stat_rdata = '0;
    if (!r_is_write) begin
      if (w_stat_off == STAT_OFF_CTRL)      w_stat_rdata = {r_err_cnt, 15'b0, r_overrun};
      else if (w_stat_off == STAT_OFF_ADDR) w_stat_rdata = r_last_err_addr;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_err_ev    = 1'b0;
    w_cpl       = 1'b0;
    w_cpl_data  = '0;
    unique case (r_state)
      ST_IDLE: begin
        if (i_m_addr_strobe) begin
          if (w_stat_hit)     w_state_nxt = ST_STAT;
          else if (w_any_hit) w_state_nxt = ST_BUSY;
          else begin
            w_state_nxt = ST_ERR;
            w_err_ev    = 1'b1;
          end
        end
      end
      ST_BUSY: begin
        // Ready beats a coincident timeout.
        if (i_s_ready[r_sel]) begin
          w_state_nxt = ST_IDLE;
          w_cpl       = 1'b1;
          w_cpl_data  = i_s_read_data[32*r_sel +: 32];
        end else if (r_tmo_cnt == TMO_LAST) begin
          w_state_nxt = ST_ERR;
          w_err_ev    = 1'b1;
        end
      end
      ST_STAT: begin
        w_state_nxt = ST_IDLE;
        w_cpl       = 1'b1;
        w_cpl_data  = w_stat_rdata;
      end
      ST_ERR: begin
        w_state_nxt = ST_IDLE;
        w_cpl       = 1'b1;
        w_cpl_data  = P_ERR_DATA;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) r_state <= ST_IDLE;
    else         r_state <= w_state_nxt;
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_sel           <= '0;
      r_tmo_cnt       <= '0;
      r_err_cnt       <= '0;
      r_last_err_addr <= '0;
      r_rd_data       <= '0;
      r_overrun       <= 1'b0;
      r_ready         <= 1'b0;
      r_is_write      <= 1'b0;
      r_be_any        <= 1'b0;
    end else begin
      r_ready <= w_cpl;
      if (w_cpl) r_rd_data <= w_cpl_data;
      if (r_state == ST_IDLE && i_m_addr_strobe) begin
        r_sel      <= w_sel;
        r_is_write <= i_m_write_strobe;
        r_be_any   <= |i_m_byte_enable;
      end
      if (r_state == ST_BUSY) r_tmo_cnt <= r_tmo_cnt + TMO_W'(1);
      else                    r_tmo_cnt <= '0;
      // An error in the same cycle as a clear leaves exactly one error counted.
      if (w_err_ev) begin
        r_last_err_addr <= i_m_address;
        if (w_clr)                     r_err_cnt <= 16'd1;
        else if (r_err_cnt != 16'hFFFF) r_err_cnt <= r_err_cnt + 16'd1;
      end else if (w_clr) begin
        r_err_cnt <= '0;
      end
      if (i_m_addr_strobe && r_state != ST_IDLE) r_overrun <= 1'b1;
      else if (w_clr)                            r_overrun <= 1'b0;
    end
  end

endmodule
